l1_cache: RTL and testbench

//  Direct-mapped, write-back, write-allocate L1 cache between the LC-3b CPU memory port and physical memory.
//  8 sets x 128-bit lines, 16-bit word CPU interface, 128-bit line-wide pmem interface.

---
 rtl/l1_cache_pkg.sv | 37 +++
 rtl/l1_cache_if.sv | 44 ++++
 rtl/l1_cache_control.sv | 83 ++++++++
 rtl/l1_cache.sv | 94 +++++++++
 tb/tb_l1_cache.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/l1_cache_pkg.sv
// Shared LC-3b cache types: address fields, line/word widths and controller states.
// Address helpers keep the tag/index/offset split in one place.
package l1_cache_pkg;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_line;
   typedef logic [8:0]   lc3b_tag;
   typedef logic [2:0]   lc3b_c_index;
   typedef logic [2:0]   lc3b_c_offset;
   typedef logic [1:0]   lc3b_mem_wmask;
   typedef logic [6:0]   lc3b_line_addr;

   typedef enum logic [1:0] {
      cs_idle,
      cs_writeback,
      cs_allocate
   } lc3b_cache_state;

   localparam int NUM_SETS = 8;

   function automatic lc3b_tag addr_tag(input lc3b_word a);
      return a[15:7];
   endfunction

   function automatic lc3b_c_index addr_index(input lc3b_word a);
      return a[6:4];
   endfunction

   function automatic lc3b_c_offset addr_offset(input lc3b_word a);
      return a[3:1];
   endfunction

   function automatic lc3b_word line_base(input lc3b_tag t, input lc3b_c_index i);
      return {t, i, 4'b0000};
   endfunction

endpackage

// File: rtl/l1_cache_if.sv
// CPU word port and physical-memory line port of the L1 cache.
// Requests are level-held by the master until the slave's resp pulse.
interface l1_cpu_if;
   import l1_cache_pkg::*;

   lc3b_word      mem_address;
   logic          mem_read;
   logic          mem_write;
   lc3b_mem_wmask mem_wmask;
   lc3b_word      mem_wdata;
   lc3b_word      mem_rdata;
   logic          mem_resp;

   modport master (
      output mem_address, mem_read, mem_write, mem_wmask, mem_wdata,
      input  mem_rdata, mem_resp
   );

   modport slave (
      input  mem_address, mem_read, mem_write, mem_wmask, mem_wdata,
      output mem_rdata, mem_resp
   );
endinterface

interface l1_pmem_if;
   import l1_cache_pkg::*;

   lc3b_word pmem_address;
   logic     pmem_read;
   logic     pmem_write;
   lc3b_line pmem_wdata;
   lc3b_line pmem_rdata;
   logic     pmem_resp;

   modport master (
      output pmem_address, pmem_read, pmem_write, pmem_wdata,
      input  pmem_rdata, pmem_resp
   );

   modport slave (
      input  pmem_address, pmem_read, pmem_write, pmem_wdata,
      output pmem_rdata, pmem_resp
   );
endinterface

// File: rtl/l1_cache_control.sv
// Cache controller FSM: hit service in IDLE, victim writeback, then line allocate.
// Hits respond in the request cycle; misses hold pmem strobes until pmem_resp.
module cache_control
   import l1_cache_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic hit,
   input  logic dirty,
   input  logic mem_read,
   input  logic mem_write,
   input  logic pmem_resp,
   output logic mem_resp,
   output logic pmem_read,
   output logic pmem_write,
   output logic load_line,
   output logic load_word,
   output logic addr_sel
);

   lc3b_cache_state state, next_state;
   logic            req;

   assign req = mem_read | mem_write;

   always_ff @(posedge clk) begin
      if (!reset_n)
         state <= cs_idle;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      mem_resp   = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      load_line  = 1'b0;
      load_word  = 1'b0;
      addr_sel   = 1'b0;

      unique case (state)
         cs_idle: begin
            if (req) begin
               if (hit) begin
                  mem_resp  = 1'b1;
                  load_word = mem_write;
               end else if (dirty) begin
                  next_state = cs_writeback;
               end else begin
                  next_state = cs_allocate;
               end
            end
         end
         cs_writeback: begin
            pmem_write = 1'b1;
            addr_sel   = 1'b1;
            if (pmem_resp)
               next_state = cs_allocate;
         end
         cs_allocate: begin
            pmem_read = 1'b1;
            if (pmem_resp) begin
               load_line  = 1'b1;
               next_state = cs_idle;
            end
         end
         default: next_state = cs_idle;
      endcase

      // Reset wins over any in-flight completion: no array write, no resp.
      if (!reset_n) begin
         next_state = cs_idle;
         mem_resp   = 1'b0;
         pmem_read  = 1'b0;
         pmem_write = 1'b0;
         load_line  = 1'b0;
         load_word  = 1'b0;
         addr_sel   = 1'b0;
      end
   end

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped write-back/write-allocate L1: 8 x 128-bit lines, 16-bit CPU words.
// Hit latency 0; clean miss = fill + 1; dirty miss = writeback + fill + 1.
module l1_cache
   import l1_cache_pkg::*;
(
   input  logic      clk,
   input  logic      reset_n,
   l1_cpu_if.slave   cpu,
   l1_pmem_if.master pmem
);

   logic [NUM_SETS-1:0] valid;
   logic [NUM_SETS-1:0] dirty;
   lc3b_tag             tag_arr  [NUM_SETS];
   lc3b_line            data_arr [NUM_SETS];

   lc3b_tag      tag;
   lc3b_c_index  idx;
   lc3b_c_offset off;
   lc3b_line     cur_line;
   lc3b_line     merged;
   lc3b_word     cur_word;
   logic         hit;
   logic         victim_dirty;

   logic mem_resp, pmem_read, pmem_write, load_line, load_word, addr_sel;
   logic unused_addr_lsb;

   assign tag             = addr_tag(cpu.mem_address);
   assign idx             = addr_index(cpu.mem_address);
   assign off             = addr_offset(cpu.mem_address);
   assign unused_addr_lsb = cpu.mem_address[0];

   assign cur_line     = data_arr[idx];
   assign cur_word     = cur_line[{off, 4'b0000} +: 16];
   assign hit          = valid[idx] && (tag_arr[idx] == tag);
   assign victim_dirty = valid[idx] && dirty[idx];

   always_comb begin
      merged = cur_line;
      if (cpu.mem_wmask[0])
         merged[{off, 4'b0000} +: 8] = cpu.mem_wdata[7:0];
      if (cpu.mem_wmask[1])
         merged[{off, 4'b1000} +: 8] = cpu.mem_wdata[15:8];
   end

   cache_control u_ctrl (
      .clk        (clk),
      .reset_n    (reset_n),
      .hit        (hit),
      .dirty      (victim_dirty),
      .mem_read   (cpu.mem_read),
      .mem_write  (cpu.mem_write),
      .pmem_resp  (pmem.pmem_resp),
      .mem_resp   (mem_resp),
      .pmem_read  (pmem_read),
      .pmem_write (pmem_write),
      .load_line  (load_line),
      .load_word  (load_word),
      .addr_sel   (addr_sel)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid <= '0;
         dirty <= '0;
      end else if (load_line) begin
         valid[idx] <= 1'b1;
         dirty[idx] <= 1'b0;
      end else if (load_word && (cpu.mem_wmask != 2'b00)) begin
         dirty[idx] <= 1'b1;
      end
   end

   // Tag and data storage carry no reset; valid gates every use.
   always_ff @(posedge clk) begin
      if (load_line) begin
         data_arr[idx] <= pmem.pmem_rdata;
         tag_arr[idx]  <= tag;
      end else if (load_word) begin
         data_arr[idx] <= merged;
      end
   end

   assign cpu.mem_resp   = mem_resp;
   assign cpu.mem_rdata  = mem_resp ? cur_word : '0;

   assign pmem.pmem_read    = pmem_read;
   assign pmem.pmem_write   = pmem_write;
   assign pmem.pmem_wdata   = pmem_write ? cur_line : '0;
   assign pmem.pmem_address = !(pmem_read || pmem_write) ? '0 :
                              addr_sel ? line_base(tag_arr[idx], idx) : line_base(tag, idx);

endmodule

// File: tb/tb_l1_cache.sv
// Scoreboarded bench for l1_cache with a fixed-latency line memory model.
module tb_l1_cache;
   import l1_cache_pkg::*;

   localparam int PM_LAT = 4;
   localparam int CLEAN  = PM_LAT + 1;
   localparam int DIRTY  = 2 * PM_LAT + 1;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   l1_cpu_if  cpu_bus ();
   l1_pmem_if pmem_bus ();

   l1_cache dut (
      .clk     (clk),
      .reset_n (reset_n),
      .cpu     (cpu_bus),
      .pmem    (pmem_bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   lc3b_line    pm      [4096];
   lc3b_line    ref_ln  [4096];
   logic [15:0] exp_q   [$];

   int          pm_cnt = 0;
   int          n_rd = 0;
   int          n_wr = 0;
   logic [15:0] last_rd_addr = '0;
   logic [15:0] last_wr_addr = '0;
   lc3b_line    last_wr_data = '0;
   int unsigned pm_resp_cyc = 0;
   int unsigned mem_resp_cyc = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Line memory: answers a held strobe after PM_LAT cycles with a one-cycle resp.
   initial begin
      int la;
      pmem_bus.pmem_resp  = 1'b0;
      pmem_bus.pmem_rdata = '0;
      forever begin
         @(negedge clk);
         pmem_bus.pmem_resp = 1'b0;
         if (!reset_n) begin
            pm_cnt = 0;
         end else if (pmem_bus.pmem_read || pmem_bus.pmem_write) begin
            pm_cnt++;
            if (pm_cnt == PM_LAT) begin
               pm_cnt = 0;
               la = int'(pmem_bus.pmem_address[15:4]);
               check_eq("strobe_excl", 128'(pmem_bus.pmem_read && pmem_bus.pmem_write), 128'(0));
               if (pmem_bus.pmem_write) begin
                  check_eq("wb_line", pmem_bus.pmem_wdata, ref_ln[la]);
                  n_wr++;
                  last_wr_addr = pmem_bus.pmem_address;
                  last_wr_data = pmem_bus.pmem_wdata;
                  pm[la] = pmem_bus.pmem_wdata;
               end else begin
                  n_rd++;
                  last_rd_addr = pmem_bus.pmem_address;
                  pmem_bus.pmem_rdata = pm[la];
               end
               pmem_bus.pmem_resp = 1'b1;
               pm_resp_cyc = cyc;
            end
         end
      end
   end

   // Called at a negedge; returns at a later negedge with the request dropped.
   task automatic access(input logic [15:0] addr, input logic rd, input logic wr,
                         input logic [15:0] wd, input logic [1:0] wm,
                         input int exp_lat, input string tag);
      int          la;
      int          wi;
      int          lat;
      logic        done;
      logic [15:0] e;
      la = int'(addr[15:4]);
      wi = int'(addr[3:1]);
      cpu_bus.mem_address = addr;
      cpu_bus.mem_read    = rd;
      cpu_bus.mem_write   = wr;
      cpu_bus.mem_wdata   = wd;
      cpu_bus.mem_wmask   = wm;
      if (wr) begin
         if (wm[0]) ref_ln[la][wi*16 +: 8]   = wd[7:0];
         if (wm[1]) ref_ln[la][wi*16+8 +: 8] = wd[15:8];
      end else if (rd) begin
         exp_q.push_back(ref_ln[la][wi*16 +: 16]);
      end
      lat  = 0;
      done = 1'b0;
      while (!done && lat < 200) begin
         #1;
         if (cpu_bus.mem_resp) begin
            done = 1'b1;
            mem_resp_cyc = cyc;
            if (!wr) begin
               if (exp_q.size() == 0) begin
                  check_eq({tag, "_sb_empty"}, 128'(1), 128'(0));
               end else begin
                  e = exp_q.pop_front();
                  check_eq({tag, "_rdata"}, 128'(cpu_bus.mem_rdata), 128'(e));
               end
            end
         end else begin
            @(negedge clk);
            lat++;
         end
      end
      if (!done) begin
         check_eq({tag, "_done"}, 128'(done), 128'(1));
         if (!wr && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (exp_lat >= 0) check_eq({tag, "_lat"}, 128'(lat), 128'(exp_lat));
      @(posedge clk);
      #1;
      cpu_bus.mem_read  = 1'b0;
      cpu_bus.mem_write = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_rd;
      int base_wr;
      int wait_n;
      logic [15:0] a;

      for (int la = 0; la < 4096; la++)
         for (int w = 0; w < 8; w++)
            pm[la][w*16 +: 16] = 16'(la * 8 + w) ^ 16'hA5A5;
      for (int w = 0; w < 8; w++)
         pm[1][w*16 +: 16] = 16'((w + 1) * 16'h1111);
      for (int la = 0; la < 4096; la++)
         ref_ln[la] = pm[la];

      cpu_bus.mem_address = '0;
      cpu_bus.mem_read    = 1'b0;
      cpu_bus.mem_write   = 1'b0;
      cpu_bus.mem_wdata   = '0;
      cpu_bus.mem_wmask   = '0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_mem_resp",   128'(cpu_bus.mem_resp),    128'(0));
      check_eq("rst_pmem_read",  128'(pmem_bus.pmem_read),  128'(0));
      check_eq("rst_pmem_write", 128'(pmem_bus.pmem_write), 128'(0));
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      check_eq("idle_pmem_addr", 128'(pmem_bus.pmem_address), 128'(0));
      @(negedge clk);

      // 1: clean miss fill
      base_rd = n_rd;
      base_wr = n_wr;
      access(16'h0010, 1'b1, 1'b0, 16'h0, 2'b00, CLEAN, "t1");
      check_eq("t1_n_rd",    128'(n_rd - base_rd), 128'(1));
      check_eq("t1_rd_addr", 128'(last_rd_addr),   128'(16'h0010));
      check_eq("t1_n_wr",    128'(n_wr - base_wr), 128'(0));
      check_eq("t1_gap",     128'(mem_resp_cyc - pm_resp_cyc), 128'(1));

      // 2: hit on last word
      base_rd = n_rd;
      access(16'h001E, 1'b1, 1'b0, 16'h0, 2'b00, 0, "t2");
      check_eq("t2_n_rd", 128'(n_rd - base_rd), 128'(0));

      // 3: low-byte write hit then read back
      access(16'h0012, 1'b0, 1'b1, 16'hABCD, 2'b01, 0, "t3w");
      access(16'h0012, 1'b1, 1'b0, 16'h0, 2'b00, 0, "t3r");

      // 4: conflict miss on dirty line -> writeback then fill
      base_rd = n_rd;
      base_wr = n_wr;
      access(16'h0092, 1'b1, 1'b0, 16'h0, 2'b00, DIRTY, "t4");
      check_eq("t4_n_wr",    128'(n_wr - base_wr), 128'(1));
      check_eq("t4_wr_addr", 128'(last_wr_addr),   128'(16'h0010));
      check_eq("t4_wr_w1",   128'(last_wr_data[31:16]), 128'(16'h22CD));
      check_eq("t4_rd_addr", 128'(last_rd_addr),   128'(16'h0090));
      access(16'h0012, 1'b1, 1'b0, 16'h0, 2'b00, CLEAN, "t4b");
      check_eq("t4b_n_wr",   128'(n_wr - base_wr), 128'(1));

      // 5: reset during allocate
      base_rd = n_rd;
      cpu_bus.mem_address = 16'h0020;
      cpu_bus.mem_read    = 1'b1;
      wait_n = 0;
      do begin
         @(negedge clk);
         #1;
         wait_n++;
      end while (!pmem_bus.pmem_read && wait_n < 20);
      check_eq("t5_pread_pre", 128'(pmem_bus.pmem_read), 128'(1));
      reset_n = 1'b0;
      cpu_bus.mem_read = 1'b0;
      @(posedge clk);
      #1;
      check_eq("t5_pread_post",  128'(pmem_bus.pmem_read),  128'(0));
      check_eq("t5_pwrite_post", 128'(pmem_bus.pmem_write), 128'(0));
      check_eq("t5_mem_resp",    128'(cpu_bus.mem_resp),    128'(0));
      @(negedge clk);
      reset_n = 1'b1;
      for (int la = 0; la < 4096; la++)
         ref_ln[la] = pm[la];
      @(negedge clk);
      check_eq("t5_no_fill", 128'(n_rd - base_rd), 128'(0));
      access(16'h0010, 1'b1, 1'b0, 16'h0, 2'b00, CLEAN, "t5r");
      check_eq("t5r_rd_addr", 128'(last_rd_addr), 128'(16'h0010));

      // 6: zero-mask write leaves line clean
      base_wr = n_wr;
      access(16'h0014, 1'b0, 1'b1, 16'hFFFF, 2'b00, 0, "t6w");
      access(16'h0014, 1'b1, 1'b0, 16'h0, 2'b00, 0, "t6r");
      access(16'h0094, 1'b1, 1'b0, 16'h0, 2'b00, CLEAN, "t6e");
      check_eq("t6_n_wr", 128'(n_wr - base_wr), 128'(0));

      // 7: read+write together acts as a write; high-byte merge; dirty eviction
      access(16'h0096, 1'b1, 1'b1, 16'h1234, 2'b10, 0, "t7w");
      access(16'h0096, 1'b1, 1'b0, 16'h0, 2'b00, 0, "t7r");
      access(16'h0016, 1'b1, 1'b0, 16'h0, 2'b00, DIRTY, "t7e");
      check_eq("t7_wr_addr", 128'(last_wr_addr), 128'(16'h0090));

      // 8: random traffic over a few conflicting tags
      for (int n = 0; n < 80; n++) begin
         a = 16'(($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 7) << 1));
         if ($urandom_range(0, 1) == 0)
            access(a, 1'b1, 1'b0, 16'h0, 2'b00, -1, "rnd_rd");
         else
            access(a, 1'b0, 1'b1, 16'($urandom), 2'($urandom), -1, "rnd_wr");
      end
      check_eq("sb_drained", 128'(exp_q.size()), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
